// File: rtl/measure_sequencer.sv
// measure_sequencer: DDS settle, then dual-channel ADC accumulation and a valid/ready result handoff
module measure_sequencer #(
  parameter int ADC_W       = 12,
  parameter int NSAMP_LOG2  = 8,
  parameter int SETTLE_CYC  = 1000,
  parameter int MUX_SETTLE  = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                        ExtClk,
  input  logic                        ExtResetn,
  input  logic [1:0]                  FreqMode,
  input  logic                        StartMeasure,
  input  logic                        Abort,
  input  logic                        AdcValid,
  input  logic [ADC_W-1:0]            AdcData,
  output logic                        DdsEn,
  output logic [1:0]                  DdsFreqSel,
  output logic                        MuxSel,
  output logic                        AdcReq,
  output logic [ADC_W+NSAMP_LOG2-1:0] SumV,
  output logic [ADC_W+NSAMP_LOG2-1:0] SumI,
  output logic                        ResultValid,
  input  logic                        ResultReady,
  output logic                        Busy,
  output logic                        Error
);
  localparam int SW   = ADC_W + NSAMP_LOG2;
  localparam int CMAX = (SETTLE_CYC > MUX_SETTLE) ? ((SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC)
                                                  : ((MUX_SETTLE > TIMEOUT_CYC) ? MUX_SETTLE : TIMEOUT_CYC);
  localparam int CW   = $clog2(CMAX + 1);
  typedef enum logic [2:0] {IDLE, SETTLE, ACQ_V, SWITCH, ACQ_I, HOLD} state_t;
  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [NSAMP_LOG2-1:0] r_nsamp;
  logic [SW-1:0]         w_sample;
  logic                  w_last;
  assign w_sample = SW'(AdcData);
  assign w_last   = &r_nsamp;
  // r_cnt is shared: settle timer, mux timer, and acquisition watchdog
  always_ff @(posedge ExtClk or negedge ExtResetn) begin
    if (!ExtResetn) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_nsamp     <= '0;
      DdsEn       <= 1'b0;
      DdsFreqSel  <= '0;
      MuxSel      <= 1'b0;
      AdcReq      <= 1'b0;
      SumV        <= '0;
      SumI        <= '0;
      ResultValid <= 1'b0;
      Busy        <= 1'b0;
      Error       <= 1'b0;
    end else if (Abort) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_nsamp     <= '0;
      DdsEn       <= 1'b0;
      MuxSel      <= 1'b0;
      AdcReq      <= 1'b0;
      ResultValid <= 1'b0;
      Busy        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (StartMeasure) begin
          r_state    <= SETTLE;
          r_cnt      <= '0;
          DdsEn      <= 1'b1;
          DdsFreqSel <= FreqMode;
          MuxSel     <= 1'b0;
          SumV       <= '0;
          SumI       <= '0;
          Error      <= 1'b0;
          Busy       <= 1'b1;
        end
        SETTLE: if (r_cnt == CW'(SETTLE_CYC - 1)) begin
          r_state <= ACQ_V;
          r_cnt   <= '0;
          AdcReq  <= 1'b1;
        end else r_cnt <= r_cnt + 1'b1;
        ACQ_V, ACQ_I: if (AdcValid) begin
          r_cnt   <= '0;
          r_nsamp <= r_nsamp + 1'b1;
          if (r_state == ACQ_V) SumV <= SumV + w_sample;
          else SumI <= SumI + w_sample;
          if (w_last) begin
            AdcReq <= 1'b0;
            if (r_state == ACQ_V) begin
              r_state <= SWITCH;
              MuxSel  <= 1'b1;
            end else begin
              r_state     <= HOLD;
              DdsEn       <= 1'b0;
              ResultValid <= 1'b1;
            end
          end
        end else if (r_cnt == CW'(TIMEOUT_CYC - 1)) begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_nsamp <= '0;
          DdsEn   <= 1'b0;
          AdcReq  <= 1'b0;
          MuxSel  <= 1'b0;
          Busy    <= 1'b0;
          Error   <= 1'b1;
        end else r_cnt <= r_cnt + 1'b1;
        SWITCH: if (r_cnt == CW'(MUX_SETTLE - 1)) begin
          r_state <= ACQ_I;
          r_cnt   <= '0;
          AdcReq  <= 1'b1;
        end else r_cnt <= r_cnt + 1'b1;
        HOLD: if (ResultReady) begin
          r_state     <= IDLE;
          ResultValid <= 1'b0;
          MuxSel      <= 1'b0;
          Busy        <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_measure_sequencer.sv
// tb_measure_sequencer: randomized scenario bench with a phase-timeline reference model
`timescale 1ns/1ps
module tb_measure_sequencer;
  localparam int ADC_W = 12, NL = 2, SC = 10, MS = 4, TO = 32;
  localparam int NS = 1 << NL, SW = ADC_W + NL;
  logic ExtClk = 1'b0, ExtResetn = 1'b0;
  logic [1:0] FreqMode = '0;
  logic StartMeasure = 1'b0, Abort = 1'b0, AdcValid = 1'b0, ResultReady = 1'b0;
  logic [ADC_W-1:0] AdcData = '0;
  logic DdsEn, MuxSel, AdcReq, ResultValid, Busy, Error;
  logic [1:0] DdsFreqSel;
  logic [SW-1:0] SumV, SumI;
  logic [4:0] flags;
  int checks = 0, errors = 0;
  assign flags = {Busy, DdsEn, AdcReq, MuxSel, ResultValid};
  measure_sequencer #(.ADC_W(ADC_W), .NSAMP_LOG2(NL), .SETTLE_CYC(SC), .MUX_SETTLE(MS), .TIMEOUT_CYC(TO)) dut (
    .ExtClk(ExtClk), .ExtResetn(ExtResetn), .FreqMode(FreqMode), .StartMeasure(StartMeasure),
    .Abort(Abort), .AdcValid(AdcValid), .AdcData(AdcData), .DdsEn(DdsEn), .DdsFreqSel(DdsFreqSel),
    .MuxSel(MuxSel), .AdcReq(AdcReq), .SumV(SumV), .SumI(SumI), .ResultValid(ResultValid),
    .ResultReady(ResultReady), .Busy(Busy), .Error(Error)
  );
  always #5 ExtClk = ~ExtClk;
  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  task automatic tick;
    @(posedge ExtClk);
    #1;
  endtask
  task automatic noise;
    AdcValid = 1'($urandom_range(0, 1));
    AdcData  = ADC_W'($urandom);
  endtask
  task automatic start_run(input logic [1:0] fm);
    FreqMode = fm;
    StartMeasure = 1'b1;
    noise();
    tick();
    StartMeasure = 1'b0;
    FreqMode = 2'($urandom);
    checks++;
    if ({flags, Error, DdsFreqSel} !== {5'b11000, 1'b0, fm} || SumV !== '0 || SumI !== '0) begin
      errors++;
      $display("FAIL start: flags=%b err=%b sel=%0d sums=%0d/%0d exp flags=11000 err=0 sel=%0d sums=0/0", flags, Error, DdsFreqSel, SumV, SumI, fm);
    end
  endtask
  task automatic settle_phase;
    for (int i = 1; i < SC; i++) begin
      noise();
      tick();
      checks++;
      if (flags !== 5'b11000) begin errors++; $display("FAIL settle_%0d: flags=%b exp 11000", i, flags); end
    end
    noise();
    tick();
    checks++;
    if (flags !== 5'b11100) begin errors++; $display("FAIL settle_end: flags=%b exp 11100", flags); end
  endtask
  task automatic acq_phase(input bit ch, input int gap, input int dval, input bit ns, output logic [SW-1:0] es);
    int n = 0, c = 0, idle = 0;
    logic [4:0] ef;
    es = '0;
    while (n < NS && c < 200) begin
      AdcValid = (gap < 0) ? ((idle >= 3) || ($urandom_range(0, 1) == 1)) : (c % (gap + 1) == gap);
      AdcData = (dval < 0) ? ADC_W'($urandom) : ADC_W'(dval);
      StartMeasure = ns && c == 1;
      if (AdcValid) begin es += SW'(AdcData); n++; idle = 0; end else idle++;
      c++;
      tick();
      StartMeasure = 1'b0;
      ef = (n < NS) ? {3'b111, ch, 1'b0} : (ch ? 5'b10011 : 5'b11010);
      checks++;
      if (flags !== ef || (ch ? SumI : SumV) !== es) begin
        errors++;
        $display("FAIL acq_%0d: flags=%b sum=%0d exp flags=%b sum=%0d", ch, flags, ch ? SumI : SumV, ef, es);
      end
    end
    AdcValid = 1'b0;
  endtask
  task automatic switch_phase(input logic [SW-1:0] esv);
    for (int i = 1; i < MS; i++) begin
      noise();
      tick();
      checks++;
      if (flags !== 5'b11010 || SumV !== esv) begin errors++; $display("FAIL switch_%0d: flags=%b sumv=%0d exp 11010 %0d", i, flags, SumV, esv); end
    end
    noise();
    tick();
    checks++;
    if (flags !== 5'b11110) begin errors++; $display("FAIL switch_end: flags=%b exp 11110", flags); end
  endtask
  task automatic hold_phase(input logic [1:0] fm, input logic [SW-1:0] esv, input logic [SW-1:0] esi, input int wait_cyc);
    for (int i = 0; i < wait_cyc; i++) begin
      ResultReady = 1'b0;
      noise();
      tick();
      checks++;
      if (flags !== 5'b10011 || SumV !== esv || SumI !== esi || DdsFreqSel !== fm) begin
        errors++;
        $display("FAIL hold_%0d: flags=%b sums=%0d/%0d sel=%0d exp 10011 %0d/%0d sel=%0d", i, flags, SumV, SumI, DdsFreqSel, esv, esi, fm);
      end
    end
    ResultReady = 1'b1;
    noise();
    tick();
    ResultReady = 1'b0;
    checks++;
    if ({Busy, DdsEn, AdcReq, ResultValid} !== 4'b0000 || SumV !== esv || SumI !== esi || Error !== 1'b0) begin
      errors++;
      $display("FAIL handshake: flags=%b err=%b sums=%0d/%0d exp idle sums=%0d/%0d", flags, Error, SumV, SumI, esv, esi);
    end
  endtask
  task automatic do_run(input logic [1:0] fm, input int gap, input int dv, input int di, input int wait_cyc, input bit ns,
                        output logic [SW-1:0] esv, output logic [SW-1:0] esi);
    ResultReady = (wait_cyc == 0);
    start_run(fm);
    settle_phase();
    acq_phase(1'b0, gap, dv, 1'b0, esv);
    switch_phase(esv);
    acq_phase(1'b1, gap, di, ns, esi);
    hold_phase(fm, esv, esi, wait_cyc);
  endtask
  task automatic test_reset;
    ExtResetn = 1'b0;
    repeat (3) tick();
    checks++;
    if ({flags, Error, DdsFreqSel, SumV, SumI} !== '0) begin
      errors++;
      $display("FAIL reset: flags=%b err=%b sel=%0d sums=%0d/%0d exp all 0", flags, Error, DdsFreqSel, SumV, SumI);
    end
    @(negedge ExtClk);
    ExtResetn = 1'b1;
    tick();
  endtask
  task automatic test_nominal;
    logic [SW-1:0] v, i;
    do_run(2'd2, 0, 100, 50, 0, 1'b0, v, i);
    checks++;
    if (SumV !== SW'(400) || SumI !== SW'(200)) begin errors++; $display("FAIL nominal_sums: got %0d/%0d exp 400/200", SumV, SumI); end
  endtask
  task automatic test_backpressure;
    logic [SW-1:0] v, i;
    do_run(2'd1, -1, -1, -1, 20, 1'b0, v, i);
  endtask
  task automatic test_timeout;
    int cnt = 0;
    bit seen_rv = 1'b0;
    logic [SW-1:0] es = '0;
    start_run(2'd1);
    settle_phase();
    for (int k = 0; k < 2; k++) begin
      AdcValid = 1'b1;
      AdcData = ADC_W'($urandom);
      es += SW'(AdcData);
      tick();
    end
    AdcValid = 1'b0;
    do begin
      AdcData = ADC_W'($urandom);
      tick();
      cnt++;
      seen_rv |= ResultValid;
    end while (!Error && cnt < 100);
    checks++;
    if (cnt !== TO || {Busy, DdsEn, AdcReq, ResultValid, Error} !== 5'b00001 || seen_rv || SumV !== es) begin
      errors++;
      $display("FAIL timeout: cycles=%0d flags=%b err=%b rv_seen=%b sumv=%0d exp cycles=%0d flags=0 err=1 rv_seen=0 sumv=%0d", cnt, flags, Error, seen_rv, SumV, TO, es);
    end
    repeat (5) begin ResultReady = 1'b1; noise(); tick(); end
    ResultReady = 1'b0;
    checks++;
    if (Error !== 1'b1 || Busy !== 1'b0) begin errors++; $display("FAIL timeout_sticky: err=%b busy=%b exp 1 0", Error, Busy); end
    start_run(2'd3);
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
  endtask
  task automatic test_abort;
    logic [SW-1:0] v, i, pi;
    start_run(2'd3);
    tick();
    tick();
    Abort = 1'b1;
    StartMeasure = 1'b1;
    tick();
    Abort = 1'b0;
    StartMeasure = 1'b0;
    checks++;
    if (flags !== 5'b00000) begin errors++; $display("FAIL abort_settle: flags=%b exp 00000", flags); end
    repeat (6) begin noise(); tick(); end
    checks++;
    if (flags !== 5'b00000) begin errors++; $display("FAIL abort_norestart: flags=%b exp 00000", flags); end
    ResultReady = 1'b1;
    start_run(2'd0);
    settle_phase();
    acq_phase(1'b0, -1, -1, 1'b0, v);
    switch_phase(v);
    AdcValid = 1'b1;
    AdcData = ADC_W'($urandom);
    pi = SW'(AdcData);
    tick();
    Abort = 1'b1;
    StartMeasure = 1'b1;
    AdcData = ADC_W'($urandom);
    tick();
    Abort = 1'b0;
    StartMeasure = 1'b0;
    AdcValid = 1'b0;
    checks++;
    if (flags !== 5'b00000 || SumV !== v || SumI !== pi || Error !== 1'b0) begin
      errors++;
      $display("FAIL abort_acqi: flags=%b sums=%0d/%0d err=%b exp 00000 %0d/%0d err=0", flags, SumV, SumI, Error, v, pi);
    end
    do_run(2'd1, -1, -1, -1, 3, 1'b0, v, i);
  endtask
  task automatic test_fullscale;
    logic [SW-1:0] v, i;
    do_run(2'd0, 2, 4095, 4095, 0, 1'b1, v, i);
    checks++;
    if (SumV !== SW'(16380) || SumI !== SW'(16380)) begin errors++; $display("FAIL fullscale: got %0d/%0d exp 16380/16380", SumV, SumI); end
  endtask
  task automatic test_random;
    logic [SW-1:0] v, i;
    for (int r = 0; r < 4; r++)
      do_run(2'($urandom), -1, -1, -1, $urandom_range(0, 5), 1'($urandom_range(0, 1)), v, i);
  endtask
  task automatic test_async_reset;
    logic [SW-1:0] v, i;
    ResultReady = 1'b1;
    start_run(2'd2);
    settle_phase();
    acq_phase(1'b0, 0, -1, 1'b0, v);
    switch_phase(v);
    AdcValid = 1'b1;
    repeat (2) begin AdcData = ADC_W'($urandom); tick(); end
    AdcValid = 1'b0;
    #3;
    ExtResetn = 1'b0;
    #1;
    checks++;
    if ({flags, Error, DdsFreqSel, SumV, SumI} !== '0) begin
      errors++;
      $display("FAIL async_reset: flags=%b err=%b sel=%0d sums=%0d/%0d exp all 0", flags, Error, DdsFreqSel, SumV, SumI);
    end
    @(negedge ExtClk);
    ExtResetn = 1'b1;
    repeat (2) tick();
    checks++;
    if (flags !== 5'b00000) begin errors++; $display("FAIL async_release: flags=%b exp 00000", flags); end
    do_run(2'd3, -1, -1, -1, 1, 1'b0, v, i);
  endtask
  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_timeout();
    test_abort();
    test_fullscale();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
